piso_arbiter: RTL and testbench



---
 rtl/piso_arb_pkg.sv | 15 +
 rtl/piso_arb_if.sv | 30 +++
 rtl/piso_arb_pick.sv | 43 ++++
 rtl/piso_arbiter.sv | 155 +++++++++++++++
 tb/tb_piso_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/piso_arb_pkg.sv
// Shared types and constants for the PISO serializer arbiter.
// Optional feature macro used by the other files: PISO_ARB_RR_EN (round-robin arbitration).
package piso_arb_pkg;
    localparam int PISO_W     = 8;
    localparam int DATA_BITS  = 8;
    localparam int SHIFT_LAST = 14;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_ACT,
        SHIFT
    } state_t;
endpackage

// File: rtl/piso_arb_if.sv
// Bundle of requester handshake and serializer control signals around the arbiter.
// master: the arbiter's view; slave: the environment (requesters + serializer).
interface piso_arb_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        ack;
    logic [ID_W-1:0]         grant_id;
    logic                    busy;
    logic                    piso_load;
    logic [DATA_W-1:0]       piso_data;
    logic                    piso_active;
    logic                    frame_valid;
    logic                    done;
    logic                    err;

    modport master (
        input  req, req_data, piso_active,
        output ack, grant_id, busy, piso_load, piso_data, frame_valid, done, err
    );

    modport slave (
        output req, req_data, piso_active,
        input  ack, grant_id, busy, piso_load, piso_data, frame_valid, done, err
    );
endinterface

// File: rtl/piso_arb_pick.sv
// Combinational winner select among pending requests.
// PISO_ARB_RR_EN defined: round-robin search starting after ptr; otherwise lowest index wins.
module piso_arb_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             any,
    output logic [ID_W-1:0]  winner
);
`ifdef PISO_ARB_RR_EN
    localparam int SW = ID_W + 1;
    logic [SW-1:0] sum;

    // Scan N_REQ slots starting at ptr+1, wrapping modulo N_REQ; first set bit wins.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        sum    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            sum = {1'b0, ptr} + SW'(k);
            if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
            if (!any && req[sum[ID_W-1:0]]) begin
                any    = 1'b1;
                winner = sum[ID_W-1:0];
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Fixed priority: scan downwards so the lowest set index is the last write.
    always_comb begin
        any    = |req;
        winner = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[k]) winner = ID_W'(k);
        end
    end
`endif
endmodule

// File: rtl/piso_arbiter.sv
// Shares one 8-bit PISO serializer among N_REQ requesters and tracks its load,
// active and shift phases. Macro PISO_ARB_RR_EN selects round-robin arbitration
// (pointer register present); undefined gives fixed priority.
//
// state    | meaning
// IDLE     | sample req; register winner, ack, load
// LOAD     | piso_load high for this single cycle
// WAIT_ACT | wait for serializer active phase to end; error if never started
// SHIFT    | 15-cycle shift phase, frame_valid for the first 8
module piso_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
) (
    input logic      clk,
    input logic      rst,
    piso_arb_if.master bus
);
    import piso_arb_pkg::*;

    localparam int ID_W = $clog2(N_REQ);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                load_q, load_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic                busy_q, busy_d;
    logic                fv_q, fv_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                any;
    logic [ID_W-1:0]     winner;
    logic [ID_W-1:0]     ptr;

`ifdef PISO_ARB_RR_EN
    logic [ID_W-1:0]     ptr_q, ptr_d;
    assign ptr = ptr_q;
`else
    assign ptr = ID_W'(N_REQ - 1);
`endif

    piso_arb_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .any    (any),
        .winner (winner)
    );

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        load_d  = 1'b0;
        data_d  = data_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        fv_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef PISO_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (any) begin
                    ack_d[winner] = 1'b1;
                    load_d        = 1'b1;
                    data_d        = bus.req_data[winner*DATA_W +: DATA_W];
                    grant_d       = winner;
                    busy_d        = 1'b1;
                    state_d       = LOAD;
`ifdef PISO_ARB_RR_EN
                    ptr_d         = winner;
`endif
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = WAIT_ACT;
            end
            WAIT_ACT: begin
                // cnt_q==0 marks the first WAIT_ACT cycle; the serializer must be active by then.
                if (bus.piso_active) begin
                    cnt_d = CNT_W'(1);
                end else if (cnt_q == '0) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    fv_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Stay out of IDLE for the whole shift phase: a load would override shifting.
                if (cnt_q == CNT_W'(SHIFT_LAST)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    fv_d  = (cnt_q < CNT_W'(DATA_BITS - 1));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= '0;
            load_q  <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            fv_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef PISO_ARB_RR_EN
            ptr_q   <= ID_W'(N_REQ - 1);
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            load_q  <= load_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            fv_q    <= fv_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef PISO_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.ack         = ack_q;
    assign bus.piso_load   = load_q;
    assign bus.piso_data   = data_q;
    assign bus.grant_id    = grant_q;
    assign bus.busy        = busy_q;
    assign bus.frame_valid = fv_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_piso_arbiter.sv
// Self-checking bench for piso_arbiter: transaction-level timing model plus a
// behavioural serializer model driving piso_active and a serial bit stream.
`timescale 1ns/1ps
module tb_piso_arbiter;
    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int IDW = 2;
    localparam int VW  = N + 1 + DW + IDW + 4;
`ifdef PISO_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    bit   dead;

    piso_arb_if #(.N_REQ(N), .DATA_W(DW)) bus ();
    piso_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Serializer model: active for 8 cycles after load, data bits MSB first 10..17 cycles after load.
    int          ser_cnt;
    logic [7:0]  ser_sr;
    logic        ser_bit;
    always @(posedge clk) begin
        if (rst) begin
            ser_cnt <= 0;
            ser_sr  <= '0;
        end else if (bus.piso_load) begin
            ser_cnt <= 1;
            ser_sr  <= bus.piso_data;
        end else if (ser_cnt != 0 && ser_cnt < 40) begin
            ser_cnt <= ser_cnt + 1;
        end
    end
    assign bus.piso_active = !dead && ser_cnt >= 1 && ser_cnt <= 8;
    always_comb begin
        ser_bit = 1'b0;
        if (ser_cnt >= 10 && ser_cnt <= 17) ser_bit = ser_sr[3'(17 - ser_cnt)];
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Transaction-level reference model.
    int          m_L = -1000;
    int          m_w = 0;
    int          m_ptr = N - 1;
    int          m_idle_from = 0;
    bit          m_dead = 1'b0;
    logic [7:0]  m_data = '0;
    logic [IDW-1:0] m_grant = '0;
    logic [N-1:0] m_exp_ack = '0;
    logic [VW-1:0] exp_v;

    function automatic int model_pick(logic [N-1:0] r, int ptr);
        int start;
        start = RR ? ptr + 1 : 0;
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return 0;
    endfunction

    function automatic logic [VW-1:0] obs();
        return {bus.ack, bus.piso_load, bus.piso_data, bus.grant_id,
                bus.busy, bus.frame_valid, bus.done, bus.err};
    endfunction

    task automatic model_step();
        int t;
        int w;
        logic e_busy, e_fv, e_done, e_err;
        t = cyc + 1;
        if (rst) begin
            m_L = -1000; m_dead = 1'b0; m_ptr = N - 1;
            m_grant = '0; m_data = '0; m_idle_from = t;
        end else if (cyc >= m_idle_from && bus.req != '0) begin
            w = model_pick(bus.req, m_ptr);
            m_w = w; m_L = t; m_dead = dead;
            m_grant = IDW'(w);
            m_data = bus.req_data[w*DW +: DW];
            if (RR) m_ptr = w;
            m_idle_from = t + (dead ? 2 : 25);
        end
        m_exp_ack = '0;
        if (t == m_L) m_exp_ack[m_w] = 1'b1;
        if (m_dead) begin
            e_busy = (t >= m_L && t <= m_L + 1);
            e_fv   = 1'b0;
            e_done = 1'b0;
            e_err  = (t == m_L + 2);
        end else begin
            e_busy = (t >= m_L && t <= m_L + 24);
            e_fv   = (t >= m_L + 10 && t <= m_L + 17);
            e_done = (t == m_L + 25);
            e_err  = 1'b0;
        end
        exp_v = {m_exp_ack, (t == m_L), m_data, m_grant, e_busy, e_fv, e_done, e_err};
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drop_acked();
        bus.req = bus.req & ~m_exp_ack;
    endtask

    task automatic idle_wait();
        for (int i = 0; i < 60 && cyc < m_idle_from; i++) begin
            tick();
            drop_acked();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; dead = 1'b0;
        bus.req = '0; bus.req_data = '0;
        tick();
        tick();
        checks++;
        if (obs() !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", obs());
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== exp_v) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
            end
        end
    endtask

    task automatic test_single();
        int load_c = -1, fv_c = -1, done_c = -1, nbits = 0;
        logic [7:0] byte_s = '0, data_at_l = '0;
        logic [IDW-1:0] gid_at_l = '0;
        idle_wait();
        bus.req_data = {$urandom};
        bus.req_data[2*DW +: DW] = 8'hA5;
        bus.req = 4'b0100;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (obs() !== exp_v) begin
                failures++;
                $display("FAIL single cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
            end
            if (bus.piso_load && load_c < 0) begin
                load_c = cyc; data_at_l = bus.piso_data; gid_at_l = bus.grant_id;
            end
            if (bus.frame_valid) begin
                if (fv_c < 0) fv_c = cyc;
                byte_s = {byte_s[6:0], ser_bit};
                nbits++;
            end
            if (bus.done && done_c < 0) done_c = cyc;
            drop_acked();
        end
        checks++;
        if (data_at_l !== 8'hA5 || gid_at_l !== 2'd2) begin
            failures++;
            $display("FAIL single_load data=%h gid=%0d exp data=a5 gid=2", data_at_l, gid_at_l);
        end
        checks++;
        if (nbits != 8 || byte_s !== 8'hA5) begin
            failures++;
            $display("FAIL single_serial bits=%0d byte=%h exp bits=8 byte=a5", nbits, byte_s);
        end
        checks++;
        if (load_c < 0 || fv_c - load_c != 10 || done_c - load_c != 25) begin
            failures++;
            $display("FAIL single_timing fv_off=%0d done_off=%0d exp 10 25", fv_c - load_c, done_c - load_c);
        end
    endtask

    task automatic test_round_robin();
        int got[$];
        int lc[$];
        int exp_g[5];
        if (RR) exp_g = '{0, 1, 2, 3, 0};
        else    exp_g = '{0, 0, 0, 0, 0};
        bus.req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_data = {$urandom};
        bus.req = 4'b1111;
        for (int i = 0; i < 140 && got.size() < 5; i++) begin
            tick();
            checks++;
            if (obs() !== exp_v) begin
                failures++;
                $display("FAIL rr_cycle cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
            end
            if (bus.piso_load) begin
                got.push_back(int'(bus.grant_id));
                lc.push_back(cyc);
            end
        end
        bus.req = '0;
        checks++;
        if (got.size() != 5) begin
            failures++;
            $display("FAIL rr_count got=%0d exp=5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[i] != exp_g[i]) begin
                    failures++;
                    $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, got[i], exp_g[i]);
                end
            end
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (lc[i] - lc[i-1] != 26) begin
                    failures++;
                    $display("FAIL rr_spacing idx=%0d got=%0d exp=26", i, lc[i] - lc[i-1]);
                end
            end
        end
    endtask

    task automatic test_busy_request();
        int l0 = -1, ack1_c = -1;
        idle_wait();
        bus.req_data = {$urandom};
        bus.req = 4'b0001;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (obs() !== exp_v) begin
                failures++;
                $display("FAIL busy_req cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
            end
            if (bus.piso_load && l0 < 0) l0 = cyc;
            if (bus.ack[1] && ack1_c < 0) ack1_c = cyc;
            drop_acked();
            if (l0 >= 0 && cyc == l0 + 5) bus.req[1] = 1'b1;
        end
        checks++;
        if (l0 < 0 || ack1_c - l0 != 26) begin
            failures++;
            $display("FAIL busy_req_ack offset got=%0d exp=26", ack1_c - l0);
        end
    endtask

    task automatic test_dead();
        int l0 = -1, err_c = -1, busy_at = -1;
        bit fv_seen = 1'b0, done_seen = 1'b0, ack3 = 1'b0, done2 = 1'b0;
        idle_wait();
        dead = 1'b1;
        bus.req = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (obs() !== exp_v) begin
                failures++;
                $display("FAIL dead cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
            end
            if (bus.piso_load && l0 < 0) l0 = cyc;
            if (bus.err && err_c < 0) begin err_c = cyc; busy_at = int'(bus.busy); end
            if (bus.frame_valid) fv_seen = 1'b1;
            if (bus.done) done_seen = 1'b1;
            drop_acked();
        end
        checks++;
        if (l0 < 0 || err_c - l0 != 2 || busy_at != 0 || fv_seen || done_seen) begin
            failures++;
            $display("FAIL dead_err off=%0d busy=%0d fv=%0d done=%0d exp 2 0 0 0",
                     err_c - l0, busy_at, fv_seen, done_seen);
        end
        dead = 1'b0;
        bus.req = 4'b1000;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (obs() !== exp_v) begin
                failures++;
                $display("FAIL dead_recover cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
            end
            if (bus.ack[3]) ack3 = 1'b1;
            if (bus.done) done2 = 1'b1;
            drop_acked();
        end
        checks++;
        if (!ack3 || !done2) begin
            failures++;
            $display("FAIL dead_recover_txn ack3=%0d done=%0d exp 1 1", ack3, done2);
        end
    endtask

    task automatic test_reset_mid();
        int l0 = -1, first_g = -1;
        idle_wait();
        bus.req = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (l0 >= 0 && cyc == l0 + 13) begin
                checks++;
                if (obs() !== '0) begin
                    failures++;
                    $display("FAIL rst_mid_outputs got=%h exp=0", obs());
                end
            end
            checks++;
            if (obs() !== exp_v) begin
                failures++;
                $display("FAIL rst_mid cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
            end
            if (bus.piso_load && l0 < 0) l0 = cyc;
            drop_acked();
            rst = (l0 >= 0 && cyc == l0 + 12);
        end
        rst = 1'b0;
        bus.req = 4'b1001;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (obs() !== exp_v) begin
                failures++;
                $display("FAIL rst_mid_regrant cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
            end
            if (bus.piso_load && first_g < 0) first_g = int'(bus.grant_id);
            drop_acked();
        end
        checks++;
        if (first_g != 0) begin
            failures++;
            $display("FAIL rst_mid_first_grant got=%0d exp=0", first_g);
        end
    endtask

    task automatic test_withdrawn();
        int l0 = -1, nload = 0;
        bit ack1 = 1'b0;
        idle_wait();
        bus.req = 4'b0001;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if (obs() !== exp_v) begin
                failures++;
                $display("FAIL withdrawn cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
            end
            if (bus.piso_load) begin nload++; if (l0 < 0) l0 = cyc; end
            if (bus.ack[1]) ack1 = 1'b1;
            drop_acked();
            bus.req[1] = (l0 >= 0 && cyc == l0 + 14);
        end
        checks++;
        if (ack1 || nload != 1) begin
            failures++;
            $display("FAIL withdrawn_txn ack1=%0d loads=%0d exp 0 1", ack1, nload);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 700; i++) begin
            tick();
            checks++;
            if (obs() !== exp_v) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
            end
            drop_acked();
            rst = ($urandom_range(0, 199) == 0);
            if (cyc >= m_idle_from && $urandom_range(0, 9) == 0) dead = ~dead;
            for (int r = 0; r < N; r++) begin
                if (!bus.req[r] && $urandom_range(0, 5) == 0) begin
                    bus.req[r] = 1'b1;
                    bus.req_data[r*DW +: DW] = 8'($urandom);
                end else if (bus.req[r] && $urandom_range(0, 40) == 0) begin
                    bus.req[r] = 1'b0;
                end
            end
        end
        rst = 1'b0;
        dead = 1'b0;
        bus.req = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d exp finish before timeout", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_busy_request();
        test_dead();
        test_reset_mid();
        test_withdrawn();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
